clock_gen_div_n: RTL and testbench
==================================

Name: clock_gen_div_n

Overview:
- Parametrised, runtime-programmable clock divider; the successor to the fixed divide-by-2 generator.
- Divides `inClk` by an integer D ≥ 2 and produces two outputs:
  - a near-50% square wave `outClk`;
  - a one-cycle `tick` enable pulse, used to pace LED worm stepping and other slow logic.
- D can be changed on the fly with a glitch-free, period-boundary update.
- Sits between the board clock and the display/animation logic.

Parameters:
- WIDTH, 24, width of the divisor and of the internal counter.
- DEFAULT_DIV, 2, divisor loaded at reset; must be ≥ 2.

Ports:
- inClk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; when low, the divider freezes.
- divLoad  input  1  one-cycle strobe requesting a new divisor.
- divIn  input  WIDTH  requested divisor, sampled when divLoad=1.
- outClk  output  1  divided square wave, registered.
- tick  output  1  one-cycle pulse per output period, registered.
- divCur  output  WIDTH  divisor currently in effect.
- pending  output  1  a loaded divisor is waiting for the period boundary.

Behaviour:
- **Reset** (synchronous, `reset`=1 at a rising `inClk` edge):
  - Internal state: cnt=0, D=DEFAULT_DIV, pendDiv=0.
  - Outputs: outClk=0, tick=0, divCur=DEFAULT_DIV, pending=0.
  - Reset has priority over every other input.
- **Clamp:** any divIn value of 0 or 1 is treated as 2. WIDTH-bit unsigned arithmetic throughout.
- **Counter:** with H=floor(D/2), cnt runs 0..D-1.
  - On each enabled edge: cnt <= (cnt==D-1) ? 0 : cnt+1.
- **outClk:** registered, always equal to (cnt ≥ D-H).
  - Low for D-H cycles, then high for H cycles.
  - Even D gives exactly 50% duty; odd D is high one cycle less than low.
  - D=2 reproduces the legacy divide-by-2: period 2, high 1.
- **tick:** tick <= enable && (cnt==D-1).
  - High for exactly one cycle, coincident with the outClk falling edge / cnt wrap.
  - Exactly one tick per D enabled cycles.
- **enable=0:** cnt and outClk hold their values; tick=0 in the following cycle.
- **Divisor update:**
  - divLoad=1 captures clamp(divIn) into pendDiv and sets pending=1.
  - At the next enabled wrap edge (cnt==D-1): D <= pendDiv, divCur <= pendDiv, cnt <= 0, pending <= 0.
  - The current period always completes at the old D, so no runt pulses.
- **divLoad on the same edge as an enabled wrap:** the new value is applied at that wrap directly; pending stays 0.
- **divLoad while pending=1:** the newer value overwrites pendDiv (last write wins); only one update is applied.
- **divLoad or pending while enable=0:** applied on the next edge anyway.
  - D=new, cnt=0, outClk=0, pending=0, tick=0.
  - The divider restarts cleanly when re-enabled.
- **Reset mid-period or with pending=1:** pending is discarded and D returns to DEFAULT_DIV.
- **Output latency:** first rising edge of outClk occurs D-H enabled edges after reset is released.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- **Defined:**
  - Adds input port `syncIn` (1 bit), a synchronous phase-align strobe.
  - syncIn=1 on an edge forces cnt=0, outClk=0, tick=0, regardless of enable.
  - If pending=1, pendDiv is applied at that edge and pending clears.
  - Priority: reset > syncIn > divLoad/wrap.
  - divLoad on the same edge as syncIn: divIn is applied immediately.
- **Not defined:** no syncIn port; phase is set only by reset.

Test Plan:
- Reset, then enable=1, default D=2: outClk sequence 0,1,0,1…; tick high on every second edge, coincident with outClk falling; divCur=2.
- Load divIn=5 while running: pending=1 until the current D=2 period ends. Then outClk is low 3 cycles and high 2 cycles, with a tick every 5 cycles; divCur=5.
- divIn=0 and divIn=1: divCur becomes 2 after the boundary; behaviour is identical to D=2.
- D=6, drop enable for 4 cycles at cnt=2: outClk and cnt are frozen, tick=0. Resume: the remaining 3 cycles of the period complete, and the tick interval equals 6 enabled cycles.
- D=8, issue divLoad=3 then divLoad=4 before the wrap: only D=4 is applied; pending clears at the wrap; no intermediate period at D=3.
- CLKDIV_SYNC_EN defined: D=10 with syncIn pulsed at cnt=7 → next cycle cnt=0 and outClk=0; the next tick arrives exactly 10 cycles after the sync edge.

Source files
------------

// File: rtl/clock_gen_div_n.sv
`default_nettype none
// ============================================================================
// Module   : clock_gen_div_n
// Purpose  : Runtime-programmable integer clock divider. Divides inClk by
//            D >= 2 and produces a registered near-50% square wave (outClk)
//            and a one-cycle enable pulse (tick) once per output period.
//            New divisors are staged and applied only at a period boundary,
//            so the output never produces a runt pulse.
// Ports    : inClk   - system clock, all logic on its rising edge
//            reset   - synchronous active-high reset (highest priority)
//            enable  - count enable; low freezes counter and outClk
//            divLoad - one-cycle strobe requesting a new divisor
//            divIn   - requested divisor (0 and 1 are treated as 2)
//            syncIn  - phase-align strobe (only with CLKDIV_SYNC_EN)
//            outClk  - divided square wave, low D-H cycles, high H cycles
//            tick    - one-cycle pulse coincident with the counter wrap
//            divCur  - divisor currently in effect
//            pending - a loaded divisor is waiting for the period boundary
// Options  : `define CLKDIV_SYNC_EN adds the syncIn port.
// Revision : 1.0 - initial release
// ============================================================================
module clock_gen_div_n #(
    parameter int WIDTH       = 24,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             enable,
    input  logic             divLoad,
    input  logic [WIDTH-1:0] divIn,
`ifdef CLKDIV_SYNC_EN
    input  logic             syncIn,
`endif
    output logic             outClk,
    output logic             tick,
    output logic [WIDTH-1:0] divCur,
    output logic             pending
);

    localparam logic [WIDTH-1:0] c_DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_MIN_DIV = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] div_q,      div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pending_q,  pending_d;
    logic             outclk_q,   outclk_d;
    logic             tick_q,     tick_d;

    logic [WIDTH-1:0] w_div_in_clamped;
    logic [WIDTH-1:0] w_next_div;
    logic             w_last;
    logic             w_sync;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = syncIn;
`else
    assign w_sync = 1'b0;
`endif

    assign w_div_in_clamped = (divIn < c_MIN_DIV) ? c_MIN_DIV : divIn;
    assign w_last           = (cnt_q == div_q - WIDTH'(1));

    // Divisor to adopt at a restart point: a same-edge load beats a staged
    // one, which beats keeping the current divisor.
    assign w_next_div = divLoad   ? w_div_in_clamped :
                        pending_q ? pend_div_q       : div_q;

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        tick_d     = 1'b0;

        if (w_sync) begin
            // Phase realign: restart the period immediately, regardless of
            // enable, taking any requested or staged divisor on the way.
            cnt_d     = '0;
            div_d     = w_next_div;
            pending_d = 1'b0;
        end else if (enable && w_last) begin
            cnt_d     = '0;
            div_d     = w_next_div;
            pending_d = 1'b0;
            tick_d    = 1'b1;
        end else if (enable) begin
            cnt_d = cnt_q + WIDTH'(1);
            if (divLoad) begin
                pend_div_d = w_div_in_clamped;
                pending_d  = 1'b1;
            end
        end else if (divLoad || pending_q) begin
            // Frozen divider: nothing is mid-flight on the output, so adopt
            // the new divisor now and restart cleanly on re-enable.
            cnt_d     = '0;
            div_d     = w_next_div;
            pending_d = 1'b0;
        end

        // outClk is a registered copy of (cnt >= D - floor(D/2)) for the
        // state being entered, so it always tracks the counter exactly.
        outclk_d = (cnt_d >= (div_d - (div_d >> 1)));
    end

    always_ff @(posedge inClk) begin
        if (reset) begin
            cnt_q      <= '0;
            div_q      <= c_DEF_DIV;
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            outclk_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            outclk_q   <= outclk_d;
            tick_q     <= tick_d;
        end
    end

    assign outClk  = outclk_q;
    assign tick    = tick_q;
    assign divCur  = div_q;
    assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_gen_div_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_gen_div_n
// Purpose  : Self-checking bench for clock_gen_div_n. A period-level model
//            (position within the current period, period length, staged
//            divisor) predicts every output each cycle; directed sequences
//            add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_gen_div_n;

    localparam int WIDTH = 24;
    localparam int DEF   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             divLoad = 1'b0;
    logic [WIDTH-1:0] divIn = '0;
    logic             syncIn = 1'b0;
    logic             outClk;
    logic             tick;
    logic [WIDTH-1:0] divCur;
    logic             pending;

    int total = 0;
    int bad   = 0;

    clock_gen_div_n #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .inClk   (clk),
        .reset   (reset),
        .enable  (enable),
        .divLoad (divLoad),
        .divIn   (divIn),
`ifdef CLKDIV_SYNC_EN
        .syncIn  (syncIn),
`endif
        .outClk  (outClk),
        .tick    (tick),
        .divCur  (divCur),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef struct {
        int pos;   // cycles elapsed in the current output period
        int per;   // period length in effect
        int pv;    // staged divisor
        bit pf;    // staged divisor present
        bit tk;    // period just completed
    } mst_t;

    mst_t m = '{pos: 0, per: DEF, pv: 0, pf: 1'b0, tk: 1'b0};
    bit   m_valid = 1'b0;

    function automatic mst_t step(mst_t s, bit rst, bit en, bit ld, int din, bit sy);
        mst_t n;
        int   c;
        int   want;
        c    = (din < 2) ? 2 : din;
        want = ld ? c : (s.pf ? s.pv : s.per);
        n    = s;
        n.tk = 1'b0;
        if (rst) begin
            n.pos = 0; n.per = DEF; n.pv = 0; n.pf = 1'b0;
        end else if (sy) begin
            n.pos = 0; n.per = want; n.pf = 1'b0;
        end else if (en && (s.pos + 1 == s.per)) begin
            n.pos = 0; n.per = want; n.pf = 1'b0; n.tk = 1'b1;
        end else if (en) begin
            n.pos = s.pos + 1;
            if (ld) begin
                n.pv = c; n.pf = 1'b1;
            end
        end else if (ld || s.pf) begin
            n.pos = 0; n.per = want; n.pf = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m       <= step(m, reset, enable, divLoad, int'(divIn), syncIn);
        m_valid <= m_valid | reset;
    end

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model. High phase is the last
    // floor(per/2) positions of the period.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_outClk", int'(outClk), int'(m.pos >= m.per - m.per / 2));
            check("model_tick", int'(tick), int'(m.tk));
            check("model_divCur", int'(divCur), m.per);
            check("model_pending", int'(pending), int'(m.pf));
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(int v);
        divIn   = WIDTH'(v);
        divLoad = 1'b1;
        cyc();
        divLoad = 1'b0;
    endtask

    task automatic wait_pending_clear();
        int n = 0;
        while (pending && n < 64) begin
            cyc();
            n++;
        end
        check("pending_timeout", int'(pending), 0);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!tick && n < 64) begin
            cyc();
            n++;
        end
        check("tick_timeout", int'(tick), 1);
    endtask

    int n;
    int seen3;
    logic [7:0] pat_o;
    logic [7:0] pat_t;

    initial begin
        // Reset state
        repeat (2) cyc();
        check("rst_outClk", int'(outClk), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_divCur", int'(divCur), 2);
        check("rst_pending", int'(pending), 0);
        reset  = 1'b0;
        enable = 1'b1;

        // Default D=2: outClk 1,0,1,0 ; tick 0,1,0,1
        pat_o = 8'b1010;
        pat_t = 8'b0101;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("d2_outClk", int'(outClk), int'(pat_o[3-i]));
            check("d2_tick", int'(tick), int'(pat_t[3-i]));
        end

        // Load 5 mid period: staged until the D=2 period ends
        load(5);
        check("d5_pending", int'(pending), 1);
        check("d5_divCur_old", int'(divCur), 2);
        wait_pending_clear();
        check("d5_divCur", int'(divCur), 5);
        pat_o = 8'b00110;
        pat_t = 8'b00001;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("d5_outClk", int'(outClk), int'(pat_o[4-i]));
            check("d5_tick", int'(tick), int'(pat_t[4-i]));
        end

        // Clamp: 0 and 1 both behave as 2
        for (int v = 0; v < 2; v++) begin
            load(v);
            wait_pending_clear();
            check("clamp_divCur", int'(divCur), 2);
            pat_o = 8'b1010;
            for (int i = 0; i < 4; i++) begin
                cyc();
                check("clamp_outClk", int'(outClk), int'(pat_o[3-i]));
            end
        end

        // D=6 with a 4-cycle freeze at cnt=2
        load(6);
        wait_pending_clear();
        check("d6_divCur", int'(divCur), 6);
        wait_tick();
        cyc();
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("freeze_outClk", int'(outClk), 0);
            check("freeze_tick", int'(tick), 0);
        end
        enable = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 20);
        check("resume_edges", n, 4);
        check("d6_interval", 2 + n, 6);

        // D=8, two loads before the wrap: only the last one applies
        load(8);
        wait_pending_clear();
        wait_tick();
        check("d8_divCur", int'(divCur), 8);
        load(3);
        check("d8_pend_after3", int'(pending), 1);
        load(4);
        check("d8_pend_after4", int'(pending), 1);
        seen3 = 0;
        n = 0;
        while (pending && n < 64) begin
            if (divCur == 3) seen3 = 1;
            cyc();
            n++;
        end
        check("d8_pending_clear", int'(pending), 0);
        check("d8_no_d3", seen3, 0);
        check("d8_divCur_new", int'(divCur), 4);
        wait_tick();
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 20);
        check("d4_interval", n, 4);

        // Load while disabled: applied on the next edge
        enable = 1'b0;
        load(7);
        check("dis_divCur", int'(divCur), 7);
        check("dis_pending", int'(pending), 0);
        check("dis_outClk", int'(outClk), 0);
        enable = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 20);
        check("d7_first_tick", n, 7);

        // Reset with a staged divisor discards it
        load(9);
        check("rp_pending", int'(pending), 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rp_divCur", int'(divCur), 2);
        check("rp_pending_clr", int'(pending), 0);
        check("rp_outClk", int'(outClk), 0);

`ifdef CLKDIV_SYNC_EN
        // D=10, sync at cnt=7
        load(10);
        wait_pending_clear();
        wait_tick();
        repeat (7) cyc();
        syncIn = 1'b1;
        cyc();
        syncIn = 1'b0;
        check("sync_outClk", int'(outClk), 0);
        check("sync_tick", int'(tick), 0);
        n = 1;
        while (!tick && n < 30) begin
            cyc();
            n++;
        end
        check("sync_tick_dist", n, 10);
`endif

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
